// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader controller: state codes,
// default address stride and the phase-selection helper.
package mem_loader_pkg;

  localparam int ADDR_STRIDE_DEF = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_I   = 3'd1;
  localparam logic [2:0] ST_LOAD_D   = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DUMP_RD  = 3'd4;
  localparam logic [2:0] ST_DUMP_OUT = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // One bit per phase: set when that phase still has work to do.
  typedef struct packed {
    logic dump;
    logic run;
    logic load_d;
    logic load_i;
  } phase_mask_t;

  // First phase with work, in sequence order; DONE when nothing is left.
  function automatic logic [2:0] first_phase(input phase_mask_t m);
    if (m.load_i) return ST_LOAD_I;
    if (m.load_d) return ST_LOAD_D;
    if (m.run)    return ST_RUN;
    if (m.dump)   return ST_DUMP_RD;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/ld_down_counter.sv
// Loadable down-counter that saturates at zero; times the RUN phase.
module ld_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority over decrement; never decrement below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_loader_ctrl.sv
// Sequencer that streams words into CPU instruction/data memories, lets the
// CPU run for a fixed number of cycles, then streams data memory back out.
module mem_loader_ctrl
  import mem_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int ADDR_STRIDE = ADDR_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        cfg_imem_len,
  input  logic [10:0]       cfg_dmem_len,
  input  logic [CNT_W-1:0]  cfg_run_cycles,
  input  logic [10:0]       cfg_dump_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wen,
  output logic              imem_ren,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic              dmem_ren,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state_q, state_d;
  logic [10:0]       idx_q, idx_d;
  logic [9:0]        imem_len_q, imem_len_d;
  logic [10:0]       dmem_len_q, dmem_len_d;
  logic [10:0]       dump_len_q, dump_len_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              capt_q, capt_d;   // DUMP_OUT: read word already captured
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  run_cnt;
  logic [ADDR_W-1:0] idx_addr;
  phase_mask_t       cfg_mask, after_i, after_d, after_run;

  // The run counter doubles as the registered copy of cfg_run_cycles.
  ld_down_counter #(.W(CNT_W)) u_run_cnt (
    .clk        (clk),
    .rst_n      (arst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (state_q == ST_RUN),
    .count_o    (run_cnt)
  );

  assign cfg_mask  = '{dump: |cfg_dump_len, run: |cfg_run_cycles,
                       load_d: |cfg_dmem_len, load_i: |cfg_imem_len};
  assign after_i   = '{dump: |dump_len_q, run: |run_cnt,
                       load_d: |dmem_len_q, load_i: 1'b0};
  assign after_d   = '{dump: |dump_len_q, run: |run_cnt,
                       load_d: 1'b0, load_i: 1'b0};
  assign after_run = '{dump: |dump_len_q, run: 1'b0,
                       load_d: 1'b0, load_i: 1'b0};

  assign idx_addr = ADDR_W'(idx_q) * ADDR_W'(ADDR_STRIDE);

  // Next-state logic; abort overrides everything including start.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    imem_len_d = imem_len_q;
    dmem_len_d = dmem_len_q;
    dump_len_d = dump_len_q;
    m_data_d   = m_data_q;
    capt_d     = capt_q;
    cnt_load   = 1'b0;
    cnt_val    = cfg_run_cycles;
    if (abort) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      m_data_d = '0;
      capt_d   = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            imem_len_d = cfg_imem_len;
            dmem_len_d = cfg_dmem_len;
            dump_len_d = cfg_dump_len;
            cnt_load   = 1'b1;
            idx_d      = '0;
            state_d    = first_phase(cfg_mask);
          end
        end
        ST_LOAD_I: begin
          if (s_valid) begin
            if (idx_q == ({1'b0, imem_len_q} - 11'd1)) begin
              idx_d   = '0;
              state_d = first_phase(after_i);
            end else begin
              idx_d = idx_q + 11'd1;
            end
          end
        end
        ST_LOAD_D: begin
          if (s_valid) begin
            if (idx_q == (dmem_len_q - 11'd1)) begin
              idx_d   = '0;
              state_d = first_phase(after_d);
            end else begin
              idx_d = idx_q + 11'd1;
            end
          end
        end
        ST_RUN: begin
          if (run_cnt <= CNT_W'(1)) begin
            state_d = first_phase(after_run);
          end
        end
        ST_DUMP_RD: begin
          capt_d  = 1'b0;
          state_d = ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (!capt_q) begin
            // First cycle here: the memory is now presenting the read word.
            m_data_d = dmem_rdata;
            capt_d   = 1'b1;
          end else if (m_ready) begin
            capt_d = 1'b0;
            if (idx_q == (dump_len_q - 11'd1)) begin
              idx_d   = '0;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 11'd1;
              state_d = ST_DUMP_RD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      imem_len_q <= '0;
      dmem_len_q <= '0;
      dump_len_q <= '0;
      m_data_q   <= '0;
      capt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      imem_len_q <= imem_len_d;
      dmem_len_q <= dmem_len_d;
      dump_len_q <= dump_len_d;
      m_data_q   <= m_data_d;
      capt_q     <= capt_d;
    end
  end

  // Memory-port and stream outputs are gated by state so idle buses read 0.
  assign s_ready    = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
  assign imem_wen   = (state_q == ST_LOAD_I) && s_valid;
  assign imem_ren   = 1'b0;
  assign imem_addr  = (state_q == ST_LOAD_I) ? idx_addr : '0;
  assign imem_wdata = (state_q == ST_LOAD_I) ? s_data : '0;
  assign dmem_wen   = (state_q == ST_LOAD_D) && s_valid;
  assign dmem_ren   = (state_q == ST_DUMP_RD);
  assign dmem_addr  = ((state_q == ST_LOAD_D) || (state_q == ST_DUMP_RD)) ? idx_addr : '0;
  assign dmem_wdata = (state_q == ST_LOAD_D) ? s_data : '0;
  assign m_valid    = (state_q == ST_DUMP_OUT) && capt_q;
  assign m_data     = m_data_q;
  assign cpu_enable = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Self-checking bench for mem_loader_ctrl: table-driven sequences with a
// write/dump scoreboard, plus hand-written reset, bubble and abort cases.
module tb_mem_loader_ctrl;

  logic        clk = 1'b0;
  logic        arst_n, start, abort, s_valid, m_ready;
  logic [9:0]  cfg_imem_len;
  logic [10:0] cfg_dmem_len, cfg_dump_len;
  logic [15:0] cfg_run_cycles;
  logic [31:0] s_data, m_data, imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        s_ready, m_valid, imem_wen, imem_ren, dmem_wen, dmem_ren;
  logic        cpu_enable, busy, done;

  always #5 clk = ~clk;

  mem_loader_ctrl dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
    .cfg_imem_len(cfg_imem_len), .cfg_dmem_len(cfg_dmem_len),
    .cfg_run_cycles(cfg_run_cycles), .cfg_dump_len(cfg_dump_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .cpu_enable(cpu_enable), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        sel;   // 0 = imem, 1 = dmem
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string name;
    int    il, dl, rc, dump;
    bit    rand_valid;
    int    hold;          // <0: random m_ready, else m_ready low for 'hold' valid cycles
    bit    fixed;
    int    exp_writes, exp_cpu, exp_ren;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  wr_t         wq[$];
  logic [31:0] dq[$];
  logic [31:0] dmem_m   [0:1023];
  logic [31:0] exp_dmem [0:1023];
  logic [31:0] bd       [0:2047];
  logic [31:0] fixed_d  [0:4];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  vec_t        tbl [7];

  // Data-memory model: one-cycle read latency, plus a bench preload port.
  always @(posedge clk) begin
    if (pre_we) dmem_m[pre_addr] <= pre_data;
    else if (dmem_wen) dmem_m[dmem_addr[11:2]] <= dmem_wdata;
    if (dmem_ren) dmem_rdata <= dmem_m[dmem_addr[11:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_ctrl"}, {s_ready, m_valid, imem_wen, imem_ren, dmem_wen, dmem_ren,
                        cpu_enable, busy, done}, '0);
    chk({nm, "_bus_a"}, {imem_addr, imem_wdata, dmem_addr}, '0);
    chk({nm, "_bus_b"}, {dmem_wdata, m_data}, '0);
  endtask

  task automatic do_start(input int il, input int dl, input int rc, input int dp);
    cfg_imem_len   = 10'(il);
    cfg_dmem_len   = 11'(dl);
    cfg_run_cycles = 16'(rc);
    cfg_dump_len   = 11'(dp);
    start = 1'b1;
    #2;
    chk("start_busy", busy, 1'b0);
    tick();
    start = 1'b0;
    cfg_imem_len   = 10'($urandom);
    cfg_dmem_len   = 11'($urandom);
    cfg_run_cycles = 16'($urandom);
    cfg_dump_len   = 11'($urandom);
  endtask

  task automatic preload(input int k, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = 10'(k);
    pre_data = d;
    exp_dmem[k] = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          beats, sent, cyc, budget, cpu, rises, rens, writes, vcnt;
    bit          finished, prev_cpu, stall_prev;
    logic [31:0] prev_data;
    wr_t         exp_w, act_w;
    beats = v.il + v.dl;
    for (int k = 0; k < v.dump; k++)
      preload(k, (k == 0) ? 32'hDEAD : (k == 1) ? 32'hBEEF : $urandom);
    for (int k = 0; k < beats; k++) begin
      bd[k] = (v.fixed && k < 5) ? fixed_d[k] : $urandom;
      if (k >= v.il) exp_dmem[k - v.il] = bd[k];
    end
    wq.delete();
    dq.delete();
    for (int j = 0; j < v.dump; j++) dq.push_back(exp_dmem[j]);
    do_start(v.il, v.dl, v.rc, v.dump);
    sent = 0; cpu = 0; rises = 0; rens = 0; writes = 0; vcnt = 0;
    finished = 0; prev_cpu = 0; stall_prev = 0; prev_data = '0;
    budget = 10 * (beats + v.dump) + v.rc + 50;
    for (cyc = 0; cyc < budget; cyc++) begin
      s_valid = (sent < beats) && (!v.rand_valid || $urandom_range(0, 1) == 1);
      s_data  = s_valid ? bd[sent] : $urandom;
      if (s_valid) begin
        exp_w.sel  = (sent >= v.il);
        exp_w.addr = 32'(((sent >= v.il) ? sent - v.il : sent) * 4);
        exp_w.data = bd[sent];
        wq.push_back(exp_w);
      end
      m_ready = (v.hold < 0) ? 1'($urandom_range(0, 1)) : (vcnt >= v.hold);
      #2;
      if (done) begin
        finished = 1;
        break;
      end
      chk("busy_in_seq", busy, 1'b1);
      chk("s_ready", s_ready, (sent < beats));
      chk("imem_ren", imem_ren, 1'b0);
      chk("wen_excl", imem_wen & dmem_wen, 1'b0);
      chk("dmem_wr_rd_excl", dmem_wen & dmem_ren, 1'b0);
      if (imem_wen || dmem_wen) begin
        writes++;
        act_w = imem_wen ? {1'b0, imem_addr, imem_wdata} : {1'b1, dmem_addr, dmem_wdata};
        if (wq.size() == 0) chk("wr_unexpected", {imem_wen, dmem_wen}, 2'b00);
        else chk("wr_record", act_w, wq.pop_front());
      end
      if (cpu_enable) begin
        cpu++;
        if (!prev_cpu) rises++;
      end
      prev_cpu = cpu_enable;
      if (dmem_ren) begin
        chk("ren_addr", dmem_addr, 32'(rens * 4));
        rens++;
      end
      if (stall_prev) begin
        chk("m_hold_valid", m_valid, 1'b1);
        chk("m_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (dq.size() == 0) chk("m_unexpected", m_valid, 1'b0);
        else chk("m_data", m_data, dq.pop_front());
        vcnt = 0;
      end else if (m_valid) begin
        vcnt++;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid) sent++;
      tick();
    end
    chk({v.name, "_reached_done"}, finished, 1'b1);
    chk({v.name, "_writes"}, writes, v.exp_writes);
    chk({v.name, "_cpu_cycles"}, cpu, v.exp_cpu);
    chk({v.name, "_cpu_contig"}, rises, (v.exp_cpu > 0) ? 1 : 0);
    chk({v.name, "_ren_pulses"}, rens, v.exp_ren);
    chk({v.name, "_wq_left"}, wq.size(), 0);
    chk({v.name, "_dq_left"}, dq.size(), 0);
    chk({v.name, "_done_ctrl"}, {busy, s_ready, cpu_enable, m_valid}, 4'b0000);
    $display("vec %s: done after %0d cycles", v.name, cyc);
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] pat;
    tbl[0] = '{"load38",      3,    2, 0,    0, 0,  0, 1,    5, 0,    0};
    tbl[1] = '{"run40",       0,    0, 5,    0, 0,  0, 0,    0, 5,    0};
    tbl[2] = '{"dump41",      0,    0, 0,    2, 0,  3, 0,    0, 0,    2};
    tbl[3] = '{"all_rand",    4,    3, 7,    3, 1, -1, 0,    7, 7,    3};
    tbl[4] = '{"i_then_dump", 1,    0, 0,    4, 1, -1, 0,    1, 0,    4};
    tbl[5] = '{"d_run_dump",  0,    5, 2,    5, 1,  2, 0,    5, 2,    5};
    tbl[6] = '{"max_len",     511, 1023, 3, 1023, 0, 0, 0, 1534, 3, 1023};
    fixed_d[0] = 32'h11; fixed_d[1] = 32'h22; fixed_d[2] = 32'h33;
    fixed_d[3] = 32'h0A; fixed_d[4] = 32'h0B;

    arst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_data = 32'hFFFF_FFFF;
    cfg_imem_len = '0; cfg_dmem_len = '0; cfg_run_cycles = '0; cfg_dump_len = '0;
    tick(); tick();
    #2;
    check_idle("reset");
    tick();
    arst_n = 1'b1;
    #2;
    check_idle("idle");
    tick();
    $display("seq reset: checked");

    // All lengths zero: straight to DONE, never busy.
    do_start(0, 0, 0, 0);
    #2;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    tick();
    #2;
    chk("zero_done_hold", {done, busy}, 2'b10);
    tick();
    $display("seq zero_len: checked");

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Bubbles in the load stream.
    pat = 4'b1001;
    do_start(2, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      s_valid = pat[c];
      s_data  = 32'h100 + 32'(c);
      #2;
      chk("bub_wen", imem_wen, pat[c]);
      if (pat[c]) begin
        chk("bub_addr", imem_addr, (c == 0) ? 0 : 4);
        chk("bub_data", imem_wdata, 32'h100 + 32'(c));
      end
      tick();
    end
    s_valid = 1'b0;
    #2;
    chk("bub_done", done, 1'b1);
    tick();
    $display("seq bubbles: checked");

    // Abort (mode 0) and reset (mode 1) in the middle of LOAD_D.
    for (int mode = 0; mode < 2; mode++) begin
      do_start(0, 4, 0, 0);
      s_valid = 1'b1;
      s_data  = 32'hAA;
      #2;
      chk("ab_w0_wen", dmem_wen, 1'b1);
      chk("ab_w0_addr", dmem_addr, 32'h0);
      tick();
      s_data = 32'hBB;
      if (mode == 0) abort = 1'b1;
      else arst_n = 1'b0;
      #2;
      tick();
      abort = 1'b0;
      arst_n = 1'b1;
      s_valid = 1'b0;
      #2;
      check_idle((mode == 0) ? "abort" : "rst_mid");
      tick();
      #2;
      chk("ab_stays_idle", {busy, done, s_ready}, 3'b000);
      tick();
      do_start(2, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
        s_valid = 1'b1;
        s_data  = 32'h55 + 32'(c);
        #2;
        chk("ab_restart_wen", imem_wen, 1'b1);
        chk("ab_restart_addr", imem_addr, 32'(c * 4));
        tick();
      end
      s_valid = 1'b0;
      #2;
      chk("ab_restart_done", done, 1'b1);
      tick();
      $display("seq %s: checked", (mode == 0) ? "abort" : "reset_mid");
    end

    // Abort wins over a simultaneous start.
    cfg_imem_len = 10'd3;
    start = 1'b1;
    abort = 1'b1;
    #2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    #2;
    check_idle("abort_prio");
    tick();
    $display("seq abort_prio: checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader_ctrl.md
MEM_LOADER_CTRL -- requirements
Module: mem_loader_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, memory word width.
REQ-002 Parameter ADDR_W, default 32, width of the external memory address ports.
REQ-003 Parameter CNT_W, default 16, width of the run-cycle counter.
REQ-004 Parameter ADDR_STRIDE, default 4, byte increment between consecutive word addresses.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 arst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle request to begin a load/run/dump sequence.
REQ-008 abort  in  1  return to IDLE.
REQ-009 cfg_imem_len  in  10  instruction words to load (0..511).
REQ-010 cfg_dmem_len  in  11  data words to load (0..1023).
REQ-011 cfg_run_cycles  in  CNT_W  cycles to hold cpu_enable high.
REQ-012 cfg_dump_len  in  11  data words to read back (0..1023).
REQ-013 s_valid, s_data[DATA_W], s_ready (out)  load stream, valid/ready.
REQ-014 m_valid (out), m_data[DATA_W] (out), m_ready (in)  dump stream, valid/ready.
REQ-015 imem_addr[ADDR_W], imem_wen, imem_ren, imem_wdata[DATA_W]  out  to CPU instruction-memory external port.
REQ-016 dmem_addr[ADDR_W], dmem_wen, dmem_ren, dmem_wdata[DATA_W]  out; dmem_rdata[DATA_W]  in  CPU data-memory external port.
REQ-017 cpu_enable  out  1  CPU execution enable.
REQ-018 busy, done  out  1  sequence in progress / sequence complete.

Function
REQ-019 States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-020 start in IDLE or DONE registers all cfg_* inputs and enters the first phase with nonzero length (order LOAD_I, LOAD_D, RUN, DUMP_RD); if all are zero, enters DONE. start is ignored in any other state.
REQ-021 s_ready = 1 only in LOAD_I and LOAD_D; handshake = s_valid & s_ready.
REQ-022 LOAD_I: imem_wen = s_valid, imem_addr = idx*ADDR_STRIDE, imem_wdata = s_data, all combinational (zero latency); idx increments only on handshake.
REQ-023 LOAD_D: same rule on dmem_wen/dmem_addr/dmem_wdata.
REQ-024 On the handshake of the last word of a phase, idx clears and the next nonzero phase is entered on the following edge.
REQ-025 RUN: cpu_enable = 1 for exactly cfg_run_cycles consecutive cycles, then the next phase; cpu_enable = 0 in every other state.
REQ-026 DUMP_RD: dmem_ren = 1 for one cycle, dmem_addr = idx*ADDR_STRIDE; next state DUMP_OUT.
REQ-027 dmem_rdata is valid one cycle after dmem_ren; DUMP_OUT captures it into m_data on entry and holds m_valid = 1 with m_data stable until m_ready.
REQ-028 On m_valid & m_ready: idx increments; go to DUMP_RD if words remain, else DONE.
REQ-029 imem_ren = 0 always; dmem_wen and dmem_ren are never both high.
REQ-030 busy = 1 in all states except IDLE and DONE; done = 1 only in DONE; DONE holds until start or abort.
REQ-031 abort, in any state, forces IDLE on the next edge; pending stream data is dropped; abort has priority over start.
REQ-032 idx is 11 bits; a word count reaching its cfg length ends the phase, so the index never wraps.

Reset
REQ-033 When arst_n = 0 at a rising edge: state = IDLE, idx = 0, run counter = 0, m_data = 0.
REQ-034 In reset and IDLE every output is 0, including s_ready, m_valid, cpu_enable, busy, done and all address/data buses.
REQ-035 Reset mid-sequence behaves as abort; the sequence does not resume.

Structure
REQ-036 State encoding and the ADDR_STRIDE default live in a shared package, mem_loader_pkg.
REQ-037 The block has one sub-module, a loadable down-counter (ld_down_counter), used for the RUN duration.

Verification
REQ-038 Load: start with imem_len=3, dmem_len=2, s_data 0x11,0x22,0x33,0xA,0xB continuously valid -> imem writes at 0x0/0x4/0x8, then dmem writes at 0x0/0x4; s_ready falls after the 5th handshake.
REQ-039 Bubbles: s_valid pattern 1,0,0,1 with imem_len=2 -> imem_wen only in cycles 0 and 3; addresses 0x0 then 0x4.
REQ-040 Run: run_cycles=5, other lengths 0 -> cpu_enable high for exactly 5 consecutive cycles, then done=1.
REQ-041 Dump backpressure: dump_len=2, memory words 0xDEAD/0xBEEF, m_ready low for 3 cycles -> m_data 0xDEAD stable while m_valid=1; exactly one dmem_ren pulse per word; then 0xBEEF; then done.
REQ-042 Zero lengths: start with all cfg=0 -> done=1 the cycle after start, busy never 1.
REQ-043 Abort/reset in LOAD_D after 1 of 4 words -> next cycle state IDLE, all outputs 0, cpu_enable 0; a new start restarts at imem address 0x0.
